// File: rtl/me_engine.sv
// Full-search block-matching motion estimation engine.
// An 8x8 current block is matched against a 32x32 reference window over
// displacements [-r_eff, +r_eff] in both axes, using the sum of absolute
// differences. Both memories and the result registers are reachable
// through strobe-qualified read/write ports sampled in the clk domain.
module me_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  r,
  input  logic        clk_write,
  input  logic [6:0]  address_write_ref,
  input  logic [63:0] data_write_ref,
  input  logic        write_enable_ref,
  input  logic [4:0]  address_write_cur,
  input  logic [63:0] data_write_cur,
  input  logic        write_enable_cur,
  input  logic        clk_read,
  input  logic [6:0]  address_read_ref,
  input  logic [4:0]  address_read_cur,
  output logic [63:0] data_read_ref,
  output logic [63:0] data_read_cur
);

  typedef enum logic [1:0] {IDLE, CALC, CMP} state_t;

  state_t            state, state_nxt;
  logic [63:0]       ref_mem [128];
  logic [63:0]       cur_mem [32];
  logic              write_q, read_q;
  logic              write_evt, read_evt;
  logic              busy, done, start, last_cand;
  logic [3:0]        r_eff, r_clamp;
  logic signed [4:0] r_s, r_new_s;
  logic signed [4:0] dx, dy, best_dx, best_dy;
  logic [2:0]        row;
  logic [15:0]       acc, best_sad;
  logic [4:0]        base_x, win_y;
  logic [6:0]        ref_idx;
  logic [127:0]      ref_pair;
  logic [63:0]       ref_row, cur_row, cur_rd;
  logic [10:0]       row_sad;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Strobe events are rising edges of the sampled strobe levels.
  assign write_evt = clk_write & ~write_q;
  assign read_evt  = clk_read & ~read_q;
  assign busy      = (state != IDLE);

  // A start is a cur write of bit0=1 to the control word while idle.
  assign start = write_evt & write_enable_cur & (address_write_cur == 5'h1F)
               & data_write_cur[0] & ~busy;

  assign r_clamp   = (r > 4'd8) ? 4'd8 : r;
  assign r_new_s   = $signed({1'b0, r_clamp});
  assign r_s       = $signed({1'b0, r_eff});
  assign last_cand = (dx == r_s) && (dy == r_s);

  // Candidate row fetch: the 8 pixels starting at window column 8+dx can
  // straddle two adjacent ref words, so take both and byte-shift.
  assign base_x   = $unsigned(dx) + 5'd8;
  assign win_y    = $unsigned(dy) + 5'd8 + {2'b00, row};
  assign ref_idx  = {win_y, base_x[4:3]};
  assign ref_pair = {ref_mem[ref_idx + 7'd1], ref_mem[ref_idx]};
  assign ref_row  = 64'(ref_pair >> {base_x[2:0], 3'b000});
  assign cur_row  = cur_mem[{2'b00, row}];

  // Sum of the 8 absolute pixel differences of the current row.
  always_comb begin
    row_sad = '0;
    for (int k = 0; k < 8; k++)
      row_sad = row_sad + {3'b000, abs_diff(cur_row[8*k +: 8], ref_row[8*k +: 8])};
  end

  // Cur read mux with the result registers overlaid on the top words.
  always_comb begin
    case (address_read_cur)
      5'h1C:   cur_rd = {48'b0, best_sad};
      5'h1D:   cur_rd = {48'b0, {3{best_dy[4]}}, best_dy, {3{best_dx[4]}}, best_dx};
      5'h1E:   cur_rd = {62'b0, done, busy};
      default: cur_rd = cur_mem[address_read_cur];
    endcase
  end

  // Strobe history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      // NOTE: state is always updated with <= so every flop samples pre-edge values.
      write_q <= clk_write;
      read_q  <= clk_read;
    end
  end

  // Memory writes, blocked for the whole duration of a search.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the memories must read back zero after reset, so they are flops
      // with an async clear rather than an inferred RAM.
      for (int i = 0; i < 128; i++) ref_mem[i] <= '0;
      for (int i = 0; i < 32; i++)  cur_mem[i] <= '0;
    end else if (write_evt && !busy) begin
      if (write_enable_ref) ref_mem[address_write_ref] <= data_write_ref;
      if (write_enable_cur) cur_mem[address_write_cur] <= data_write_cur;
    end
  end

  // Registered read ports; a same-edge write is seen only on the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_read_ref <= '0;
      data_read_cur <= '0;
    end else if (read_evt) begin
      data_read_ref <= ref_mem[address_read_ref];
      data_read_cur <= cur_rd;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: 8 CALC cycles then one CMP per candidate.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (row == 3'd7) state_nxt = CMP;
      CMP:     state_nxt = last_cand ? IDLE : CALC;
      default: state_nxt = IDLE;
    endcase
  end

  // Search datapath: candidate counters, accumulator and best result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_eff    <= '0;
      dx       <= '0;
      dy       <= '0;
      row      <= '0;
      acc      <= '0;
      best_sad <= '0;
      best_dx  <= '0;
      best_dy  <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r_eff    <= r_clamp;
            dx       <= -r_new_s;
            dy       <= -r_new_s;
            row      <= '0;
            acc      <= '0;
            best_sad <= 16'hFFFF;
            best_dx  <= '0;
            best_dy  <= '0;
            done     <= 1'b0;
          end
        end
        CALC: begin
          acc <= acc + {5'b0, row_sad};
          row <= row + 3'd1;
        end
        CMP: begin
          // Strict comparison keeps the first minimum in scan order.
          if (acc < best_sad) begin
            best_sad <= acc;
            best_dx  <= dx;
            best_dy  <= dy;
          end
          acc <= '0;
          if (dx == r_s) begin
            dx <= -r_s;
            dy <= dy + 5'sd1;
          end else begin
            dx <= dx + 5'sd1;
          end
          if (last_cand) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_me_engine.sv
// Self-checking bench for me_engine: directed scenarios plus randomized
// searches checked against a pixel-level full-search reference model.
module tb_me_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  r = '0;
  logic        clk_write = 1'b0;
  logic [6:0]  address_write_ref = '0;
  logic [63:0] data_write_ref = '0;
  logic        write_enable_ref = 1'b0;
  logic [4:0]  address_write_cur = '0;
  logic [63:0] data_write_cur = '0;
  logic        write_enable_cur = 1'b0;
  logic        clk_read = 1'b0;
  logic [6:0]  address_read_ref = '0;
  logic [4:0]  address_read_cur = '0;
  logic [63:0] data_read_ref;
  logic [63:0] data_read_cur;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_pix [32][32];
  logic [7:0] cur_pix [8][8];

  me_engine dut (
    .clk               (clk),
    .reset             (reset),
    .r                 (r),
    .clk_write         (clk_write),
    .address_write_ref (address_write_ref),
    .data_write_ref    (data_write_ref),
    .write_enable_ref  (write_enable_ref),
    .address_write_cur (address_write_cur),
    .data_write_cur    (data_write_cur),
    .write_enable_cur  (write_enable_cur),
    .clk_read          (clk_read),
    .address_read_ref  (address_read_ref),
    .address_read_cur  (address_read_cur),
    .data_read_ref     (data_read_ref),
    .data_read_cur     (data_read_cur)
  );

  always #5 clk = ~clk;

  // ---------------- bus helpers ----------------
  task automatic write_ref(input logic [6:0] a, input logic [63:0] d);
    @(negedge clk);
    address_write_ref = a; data_write_ref = d; write_enable_ref = 1'b1; clk_write = 1'b1;
    @(negedge clk);
    clk_write = 1'b0; write_enable_ref = 1'b0;
  endtask

  task automatic write_cur(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    address_write_cur = a; data_write_cur = d; write_enable_cur = 1'b1; clk_write = 1'b1;
    @(negedge clk);
    clk_write = 1'b0; write_enable_cur = 1'b0;
  endtask

  task automatic read_ref(input logic [6:0] a, output logic [63:0] d);
    @(negedge clk);
    address_read_ref = a; clk_read = 1'b1;
    @(negedge clk);
    d = data_read_ref; clk_read = 1'b0;
  endtask

  task automatic read_cur(input logic [4:0] a, output logic [63:0] d);
    @(negedge clk);
    address_read_cur = a; clk_read = 1'b1;
    @(negedge clk);
    d = data_read_cur; clk_read = 1'b0;
  endtask

  // Start a search and read the status word as it stands m cycles after the start edge.
  task automatic start_and_probe(input logic [3:0] rv, input int m, output logic [63:0] st);
    @(negedge clk);
    r = rv; address_write_cur = 5'h1F; data_write_cur = 64'h1;
    write_enable_cur = 1'b1; clk_write = 1'b1;
    @(negedge clk);
    clk_write = 1'b0; write_enable_cur = 1'b0;
    repeat (m) @(negedge clk);
    address_read_cur = 5'h1E; clk_read = 1'b1;
    @(negedge clk);
    st = data_read_cur; clk_read = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic [63:0] v;
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      read_cur(5'h1E, v);
      if (v[1]) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout got=%0d want=1", name, seen);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_word(input int w);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = ref_pix[w / 4][(w % 4) * 8 + k];
    return v;
  endfunction

  function automatic logic [63:0] cur_word(input int y);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = cur_pix[y][k];
    return v;
  endfunction

  task automatic load_model();
    for (int w = 0; w < 128; w++) write_ref(7'(w), ref_word(w));
    for (int y = 0; y < 8; y++) write_cur(5'(y), cur_word(y));
  endtask

  // Exhaustive SAD search in raster order; first strict minimum wins.
  task automatic model_search(input int rv, output logic [63:0] exp_sad, output logic [63:0] exp_mv);
    int re, best, bdx, bdy, s, a, b;
    re = (rv > 8) ? 8 : rv;
    best = 'hFFFF; bdx = 0; bdy = 0;
    for (int dy = -re; dy <= re; dy++)
      for (int dx = -re; dx <= re; dx++) begin
        s = 0;
        for (int y = 0; y < 8; y++)
          for (int x = 0; x < 8; x++) begin
            a = int'(cur_pix[y][x]);
            b = int'(ref_pix[8 + dy + y][8 + dx + x]);
            s += (a > b) ? a - b : b - a;
          end
        if (s < best) begin best = s; bdx = dx; bdy = dy; end
      end
    exp_sad = {48'b0, 16'(best)};
    exp_mv  = {48'b0, 8'(bdy), 8'(bdx)};
  endtask

  task automatic check_results(input string name, input logic [63:0] es, input logic [63:0] em);
    logic [63:0] v;
    read_cur(5'h1C, v);
    checks++;
    if (v !== es) begin errors++; $display("FAIL %s best_sad got=%h want=%h", name, v, es); end
    read_cur(5'h1D, v);
    checks++;
    if (v !== em) begin errors++; $display("FAIL %s best_mv got=%h want=%h", name, v, em); end
  endtask

  // Status one cycle before and exactly at 9*(2r+1)^2 cycles after start.
  task automatic check_latency(input logic [3:0] rv);
    logic [63:0] st;
    int re, lat;
    re  = (rv > 8) ? 8 : int'(rv);
    lat = 9 * (2 * re + 1) * (2 * re + 1);
    start_and_probe(rv, lat - 1, st);
    checks++;
    if (st !== 64'h1) begin errors++; $display("FAIL latency_before r=%0d got=%h want=%h", rv, st, 64'h1); end
    wait_done("latency_before");
    start_and_probe(rv, lat, st);
    checks++;
    if (st !== 64'h2) begin errors++; $display("FAIL latency_at r=%0d got=%h want=%h", rv, st, 64'h2); end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (data_read_ref !== 64'h0 || data_read_cur !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%h want=0/0", data_read_ref, data_read_cur);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int y = 0; y < 32; y++) for (int x = 0; x < 32; x++) ref_pix[y][x] = 8'h00;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) cur_pix[y][x] = 8'h00;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [63:0] v;
    pulse_reset();
    read_ref(7'h1B, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL reset_ref1b got=%h want=0", v); end
    read_cur(5'h1E, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL reset_status got=%h want=0", v); end
  endtask

  task automatic test_mem_rw();
    logic [63:0] v;
    write_ref(7'h1B, 64'hC5);
    read_ref(7'h1B, v);
    checks++;
    if (v !== 64'hC5) begin errors++; $display("FAIL ref_rw got=%h want=%h", v, 64'hC5); end
    write_cur(5'h05, 64'h0102030405060708);
    read_cur(5'h05, v);
    checks++;
    if (v !== 64'h0102030405060708) begin errors++; $display("FAIL cur_rw got=%h want=%h", v, 64'h0102030405060708); end
    // Same-edge read and write of one address returns the old word.
    write_cur(5'h06, 64'hAAAA_0000_1111_2222);
    @(negedge clk);
    address_write_cur = 5'h06; data_write_cur = 64'h5555_3333_4444_6666;
    write_enable_cur = 1'b1; clk_write = 1'b1;
    address_read_cur = 5'h06; clk_read = 1'b1;
    @(negedge clk);
    v = data_read_cur;
    clk_write = 1'b0; write_enable_cur = 1'b0; clk_read = 1'b0;
    checks++;
    if (v !== 64'hAAAA_0000_1111_2222) begin errors++; $display("FAIL rw_same_edge got=%h want=%h", v, 64'hAAAA_0000_1111_2222); end
    read_cur(5'h06, v);
    checks++;
    if (v !== 64'h5555_3333_4444_6666) begin errors++; $display("FAIL rw_after got=%h want=%h", v, 64'h5555_3333_4444_6666); end
  endtask

  task automatic test_zero_search();
    logic [63:0] st, v;
    pulse_reset();
    check_latency(4'd3);
    check_results("zero_r3", 64'h0, 64'hFDFD);
    // A fresh start clears done from its own edge.
    start_and_probe(4'd0, 0, st);
    checks++;
    if (st !== 64'h1) begin errors++; $display("FAIL restart_status got=%h want=%h", st, 64'h1); end
    wait_done("restart");
    read_cur(5'h1E, v);
    checks++;
    if (v !== 64'h2) begin errors++; $display("FAIL done_sticky got=%h want=%h", v, 64'h2); end
    check_results("zero_r0", 64'h0, 64'h0);
  endtask

  task automatic test_block_match();
    logic [63:0] st;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) cur_pix[y][x] = 8'(8 * y + x + 1);
    for (int y = 0; y < 32; y++) for (int x = 0; x < 32; x++) ref_pix[y][x] = 8'hFF;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) ref_pix[7 + y][10 + x] = cur_pix[y][x];
    load_model();
    start_and_probe(4'd4, 5, st);
    wait_done("block_match");
    check_results("block_match", 64'h0, 64'hFF02);
  endtask

  task automatic test_clamp_busy_write();
    logic [63:0] st, v, es, em;
    start_and_probe(4'd12, 10, st);
    checks++;
    if (st !== 64'h1) begin errors++; $display("FAIL busy_status got=%h want=%h", st, 64'h1); end
    write_ref(7'h1B, 64'hDEAD_BEEF_0000_0001);
    write_cur(5'h00, 64'h0);
    wait_done("clamp");
    read_ref(7'h1B, v);
    checks++;
    if (v !== ref_word(27)) begin errors++; $display("FAIL busy_write_ref got=%h want=%h", v, ref_word(27)); end
    read_cur(5'h00, v);
    checks++;
    if (v !== cur_word(0)) begin errors++; $display("FAIL busy_write_cur got=%h want=%h", v, cur_word(0)); end
    model_search(12, es, em);
    check_results("clamp_r12", es, em);
    check_latency(4'd12);
  endtask

  task automatic test_random();
    logic [63:0] st, es, em;
    int rv;
    for (int it = 0; it < 4; it++) begin
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++)
          ref_pix[y][x] = (it < 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++)
          cur_pix[y][x] = (it < 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      rv = $urandom_range(0, 15);
      load_model();
      start_and_probe(4'(rv), 0, st);
      checks++;
      if (st !== 64'h1) begin errors++; $display("FAIL rand_start it=%0d got=%h want=%h", it, st, 64'h1); end
      wait_done("random");
      model_search(rv, es, em);
      check_results($sformatf("random_it%0d_r%0d", it, rv), es, em);
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] st, v;
    start_and_probe(4'd8, 100, st);
    checks++;
    if (st !== 64'h1) begin errors++; $display("FAIL abort_busy got=%h want=%h", st, 64'h1); end
    pulse_reset();
    for (int a = 28; a <= 30; a++) begin
      read_cur(5'(a), v);
      checks++;
      if (v !== 64'h0) begin errors++; $display("FAIL abort_cur%0h got=%h want=0", a, v); end
    end
    read_cur(5'h03, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL abort_cur03 got=%h want=0", v); end
    read_ref(7'h45, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL abort_ref45 got=%h want=0", v); end
    check_latency(4'd1);
    check_results("after_abort", 64'h0, 64'hFFFF);
  endtask

  initial begin
    test_reset();
    test_mem_rw();
    test_zero_search();
    test_block_match();
    test_clamp_busy_write();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/me_engine.md
ME_ENGINE -- requirements
Module: me_engine

Interface
REQ-001 Parameters: none; all sizes below are fixed.
REQ-002 clk  in  1  sole clock; all state changes occur on rising edge of clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 r  in  4  search range; effective range r_eff = min(r, 8); sampled at start.
REQ-005 clk_write  in  1  write strobe, sampled in clk domain (not a clock).
REQ-006 address_write_ref  in  7  reference memory write address (128 words).
REQ-007 data_write_ref  in  64  reference memory write data.
REQ-008 write_enable_ref  in  1  qualifies a write-strobe event for reference memory.
REQ-009 address_write_cur  in  5  current memory write address (32 words).
REQ-010 data_write_cur  in  64  current memory write data.
REQ-011 write_enable_cur  in  1  qualifies a write-strobe event for current memory.
REQ-012 clk_read  in  1  read strobe, sampled in clk domain (not a clock).
REQ-013 address_read_ref  in  7  reference memory read address.
REQ-014 address_read_cur  in  5  current memory or result read address.
REQ-015 data_read_ref  out  64  registered reference read data.
REQ-016 data_read_cur  out  64  registered current or result read data.

Function
REQ-017 Strobe event: on a clk edge where the strobe is 1 and its previous sampled value is 0.
- Strobes are held high for at least one clk cycle.
- Address and data are held stable while a strobe is high.
REQ-018 Write event with write_enable_ref=1 stores data_write_ref at address_write_ref on that edge; the same applies to the cur port; both may occur on the same edge.
REQ-019 Read event updates data_read_ref and data_read_cur on that edge; outputs hold between events.
- A read and a write to the same address on the same edge returns the old data.
REQ-020 Pixel packing: a pixel is 8-bit unsigned; pixel k of a word occupies bits [8k+7:8k].
REQ-021 Reference window: 32x32 pixels; row y, column x at ref word 4y + x/8, byte x%8.
REQ-022 Current block: 8x8 pixels; row y at cur word y (0-7), column x at byte x.
REQ-023 Cur words 8-31 are general storage.
REQ-024 Result overlay on cur reads (the underlying memory is not altered):
- 0x1C -> {48'b0, best_sad[15:0]}
- 0x1D -> {48'b0, best_dy[7:0], best_dx[7:0]}, both two's complement
- 0x1E -> {62'b0, done, busy}
REQ-025 Start: a cur write event to address 0x1F with data bit0=1 while busy=0 starts a search.
- The word is stored normally.
- r_eff is latched; busy=1 and done=0 from that edge.
REQ-026 While busy=1, all write events to either memory are ignored; reads remain allowed.
REQ-027 Candidates are dy from -r_eff to +r_eff (outer loop) and dx from -r_eff to +r_eff (inner loop).
- Candidate block top-left is at (8+dx, 8+dy) in the window.
REQ-028 SAD = sum over 64 pixels of |cur(x,y) - ref(8+dx+x, 8+dy+y)|, computed in a 16-bit unsigned accumulator.
REQ-029 FSM states IDLE, CALC, CMP:
- CALC accumulates one row (8 absolute differences) per cycle for 8 cycles.
- CMP compares the SAD and advances the candidate (1 cycle).
- After the last CMP, go to IDLE with busy=0, done=1.
REQ-030 best_sad is initialised to 0xFFFF at start; a candidate replaces the best only if its SAD is strictly smaller, so the first minimum in scan order wins.
REQ-031 Latency: done=1 exactly 9*(2*r_eff+1)^2 cycles after the start edge.
REQ-032 done is sticky until the next start or reset; results hold after done.

Reset
REQ-033 While reset=1, regardless of clk:
- All memory words, data_read_ref, data_read_cur, best_sad, best_dx, best_dy, busy and done are 0.
- Strobe history registers are 0.
- FSM is in IDLE.
REQ-034 Reset during a search aborts it: busy=0, done=0, results 0.

Verification
REQ-035 After reset, read ref 0x1B -> 0; write ref 0x1B=0xC5 then read -> data_read_ref=0xC5.
REQ-036 Write cur 0x05=0x0102030405060708 and read it back -> that value; read cur 0x1E after reset -> 0.
REQ-037 All memories zero, r=3, start -> busy for 441 cycles, then done=1, 0x1C reads 0, 0x1D reads 0xFDFD.
REQ-038 Cur pixels distinct values 1-64; ref 0xFF everywhere except the cur block copied at (10,7); r=4 -> 0x1C reads 0, 0x1D reads 0xFF02.
REQ-039 r=12 -> clamped to 8, done after 2601 cycles; a ref write issued while busy leaves memory unchanged.
REQ-040 Reset asserted mid-search -> busy=0, done=0, all reads return 0; a new start then completes normally.
